// File: rtl/sd_ramdisk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_ramdisk_pkg
// Description : Shared types and constants for the SD block-channel ramdisk.
//               Provides the FSM state encoding, the block geometry and the
//               helper that turns an LBA width into an image size in bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_ramdisk_pkg;

  localparam int BLOCK_WORDS = 256;  // 16-bit words per block
  localparam int BLOCK_BYTES = 512;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_PRIME = 3'd1,
    S_RD_XFER  = 3'd2,
    S_WR_ADDR  = 3'd3,
    S_WR_CAP   = 3'd4,
    S_GAP      = 3'd5
  } state_e;

  // Image size in bytes for 2^lba_bits blocks.
  function automatic logic [63:0] img_bytes(input int unsigned lba_bits);
    return 64'(BLOCK_BYTES) << lba_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_ramdisk_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_ramdisk_if
// Description : hps_io style SD block channel between an initiator (save
//               sequencer) and a block responder.
//   sd_lba       - block address          (initiator -> responder)
//   sd_rd/sd_wr  - level request strobes  (initiator -> responder)
//   sd_buff_din  - write data, 1-cycle registered from sd_buff_addr
//   sd_ack       - transfer in progress   (responder -> initiator)
//   sd_buff_addr - word index within block
//   sd_buff_dout - read data
//   sd_buff_wr   - read word strobe
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_ramdisk_if;
  import sd_ramdisk_pkg::*;

  logic [31:0]                      sd_lba;
  logic                             sd_rd;
  logic                             sd_wr;
  logic                             sd_ack;
  logic [$clog2(BLOCK_WORDS)-1:0]   sd_buff_addr;
  logic [15:0]                      sd_buff_dout;
  logic [15:0]                      sd_buff_din;
  logic                             sd_buff_wr;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface
`default_nettype wire

// File: rtl/sd_ramdisk_mem.sv
`default_nettype none
// ============================================================================
// Module      : ramdisk_mem
// Description : Single-port synchronous RAM, 16-bit words, 1-cycle read
//               latency (read-before-write), no reset on contents.
//   clk     - clock
//   i_addr  - word address
//   i_we    - write enable
//   i_wdata - write data
//   o_rdata - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module ramdisk_mem #(
  parameter int ADDR_W = 14
) (
  input  wire logic              clk,
  input  wire logic [ADDR_W-1:0] i_addr,
  input  wire logic              i_we,
  input  wire logic [15:0]       i_wdata,
  output logic      [15:0]       o_rdata
);

  logic [15:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule
`default_nettype wire

// File: rtl/sd_ramdisk.sv
`default_nettype none
// ============================================================================
// Module      : sd_ramdisk
// Description : BRAM-backed responder for the hps_io SD block channel.
//               Serves sd_rd/sd_wr block requests from a private store and
//               generates the img_* mount signals.
//   clk_sys      - system clock
//   reset        - synchronous active-high reset
//   mount        - one-cycle (re)mount pulse
//   readonly     - readonly attribute, sampled with mount
//   sd           - block channel (slave side)
//   img_mounted  - one-cycle pulse after a mount is serviced
//   img_readonly - registered readonly flag
//   img_size     - image size in bytes, 0 when not mounted
//   err          - one-cycle pulse on an out-of-range LBA
// Revision    : 1.0 - initial release
// ============================================================================
module sd_ramdisk
  import sd_ramdisk_pkg::*;
#(
  parameter int LBA_BITS = 6
) (
  input  wire logic        clk_sys,
  input  wire logic        reset,
  input  wire logic        mount,
  input  wire logic        readonly,
  sd_ramdisk_if.slave      sd,
  output logic             img_mounted,
  output logic             img_readonly,
  output logic [63:0]      img_size,
  output logic             err
);

  localparam logic [2:0]  ST_IDLE     = S_IDLE;
  localparam logic [2:0]  ST_RD_PRIME = S_RD_PRIME;
  localparam logic [2:0]  ST_RD_XFER  = S_RD_XFER;
  localparam logic [2:0]  ST_WR_ADDR  = S_WR_ADDR;
  localparam logic [2:0]  ST_WR_CAP   = S_WR_CAP;
  localparam logic [2:0]  ST_GAP      = S_GAP;
  localparam logic [7:0]  C_LAST_WORD = 8'(BLOCK_WORDS - 1);
  localparam logic [63:0] C_IMG_SIZE  = img_bytes(LBA_BITS);

  logic [2:0]          r_state;
  logic [7:0]          r_cnt;
  logic [LBA_BITS-1:0] r_lba;
  logic                r_void;
  logic                r_err;
  logic                r_mounted;
  logic                r_img_mounted;
  logic                r_ro;
  logic                r_pend;
  logic                r_pend_ro;

  logic                w_lba_oor;
  logic                w_last;
  logic                w_ack;
  logic [7:0]          w_word;
  logic                w_ram_we;
  logic [15:0]         w_ram_q;

  assign w_lba_oor = (sd.sd_lba >> LBA_BITS) != 32'd0;
  assign w_last    = (r_cnt == C_LAST_WORD);
  assign w_ack     = (r_state == ST_RD_PRIME) || (r_state == ST_RD_XFER) ||
                     (r_state == ST_WR_ADDR)  || (r_state == ST_WR_CAP);

  // During a read the RAM runs one word ahead of the word being presented.
  assign w_word   = (r_state == ST_RD_XFER) ? (r_cnt + 8'd1) : r_cnt;
  // sd_buff_din is valid in WR_CAP because the initiator's buffer saw the
  // address one cycle earlier in WR_ADDR.
  assign w_ram_we = (r_state == ST_WR_CAP) && !r_void && !r_ro;

  ramdisk_mem #(
    .ADDR_W (LBA_BITS + 8)
  ) u_mem (
    .clk     (clk_sys),
    .i_addr  ({r_lba, w_word}),
    .i_we    (w_ram_we),
    .i_wdata (sd.sd_buff_din),
    .o_rdata (w_ram_q)
  );

  assign sd.sd_ack       = w_ack;
  assign sd.sd_buff_wr   = (r_state == ST_RD_XFER);
  assign sd.sd_buff_addr = w_ack ? r_cnt : 8'd0;
  assign sd.sd_buff_dout = ((r_state == ST_RD_XFER) && !r_void) ? w_ram_q : 16'h0000;

  assign err          = r_err;
  assign img_mounted  = r_img_mounted;
  assign img_readonly = r_ro;
  assign img_size     = r_mounted ? C_IMG_SIZE : 64'd0;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_lba   <= '0;
      r_void  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sd.sd_rd || sd.sd_wr) begin
            r_state <= sd.sd_rd ? ST_RD_PRIME : ST_WR_ADDR;
            r_lba   <= sd.sd_lba[LBA_BITS-1:0];
            r_void  <= w_lba_oor;
            r_err   <= w_lba_oor;
            r_cnt   <= 8'd0;
          end
        end
        ST_RD_PRIME: r_state <= ST_RD_XFER;
        ST_RD_XFER: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_last) begin
            r_state <= ST_GAP;
          end
        end
        ST_WR_ADDR: r_state <= ST_WR_CAP;
        ST_WR_CAP: begin
          r_cnt   <= r_cnt + 8'd1;
          r_state <= w_last ? ST_GAP : ST_WR_ADDR;
        end
        ST_GAP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Mounts only take effect in IDLE so img_readonly never changes under a
  // running transfer; a mount seen elsewhere is parked with its attribute.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_pend        <= 1'b0;
      r_pend_ro     <= 1'b0;
      r_mounted     <= 1'b0;
      r_img_mounted <= 1'b0;
      r_ro          <= 1'b0;
    end else begin
      r_img_mounted <= 1'b0;
      if ((r_state == ST_IDLE) && (mount || r_pend)) begin
        r_ro          <= mount ? readonly : r_pend_ro;
        r_mounted     <= 1'b1;
        r_img_mounted <= 1'b1;
        r_pend        <= 1'b0;
      end else if (mount) begin
        r_pend    <= 1'b1;
        r_pend_ro <= readonly;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/sd_ramdisk.md
# sd_ramdisk

Block-level responder for the hps_io SD block channel: serves `sd_rd`/`sd_wr` requests with a BRAM-backed image instead of the HPS. It is the target end of the backup-RAM save/load flow (`sd_lba`, `sd_ack`, `sd_buff_*`). It sits between the core's save-state sequencer and a private 16-bit block store, and is used for simulation benches and HPS-less builds. It generates `img_mounted`/`img_size`/`img_readonly` exactly as the sequencer expects them from hps_io.

## Interface
- `LBA_BITS`, default 6: number of addressable 512-byte blocks is 2^LBA_BITS (64 blocks = 32 KiB).
- `clk_sys`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `mount`  in  1  one-cycle pulse that (re)mounts the image.
- `readonly`  in  1  readonly attribute, sampled on `mount`.
- `sd_lba`  in  32  block address; sampled when a request is accepted.
- `sd_rd`  in  1  read request (level); block goes store -> initiator buffer.
- `sd_wr`  in  1  write request (level); block goes initiator buffer -> store.
- `sd_ack`  out  1  high for the whole transfer.
- `sd_buff_addr`  out  8  word index within the block.
- `sd_buff_dout`  out  16  read data to the initiator.
- `sd_buff_din`  in  16  write data from the initiator's buffer (1-cycle registered RAM).
- `sd_buff_wr`  out  1  word strobe for read transfers.
- `img_mounted`  out  1  one-cycle pulse after a mount.
- `img_readonly`  out  1  registered readonly flag.
- `img_size`  out  64  2^(LBA_BITS+9) when mounted, else 0.
- `err`  out  1  one-cycle pulse on an out-of-range LBA.

## Operation
- States: IDLE, RD_PRIME, RD_XFER, WR_ADDR, WR_CAP, GAP.
- IDLE accepts requests by level.
  - `sd_rd` high -> RD_PRIME. `sd_rd` has priority when both are high.
  - `sd_wr` high -> WR_ADDR.
  - On accept, latch `sd_lba`. If `sd_lba >= 2^LBA_BITS`, pulse `err` and mark the transfer void.
- Read transfer:
  - RD_PRIME issues the RAM read for word 0.
  - RD_XFER runs for 256 cycles. Each cycle drives `sd_buff_wr=1`, `sd_buff_addr=i`, `sd_buff_dout=mem[lba][i]`, and prefetches word i+1.
  - A void read returns 0x0000 for every word.
- Write transfer:
  - Word i: WR_ADDR drives `sd_buff_addr=i`, then WR_CAP holds it. At the end of WR_CAP, `sd_buff_din` is captured and written to `mem[lba][i]`.
  - The RAM write is suppressed when the transfer is void or `img_readonly=1`. The handshake still completes in full.
- After word 255, enter GAP for one cycle with `sd_ack=0`, then return to IDLE.
- Mount:
  - A `mount` pulse in IDLE registers `readonly`, sets `img_size`, and pulses `img_mounted` on the next cycle.
  - A `mount` pulse outside IDLE is held pending and serviced on entry to IDLE.
  - Memory contents are never cleared.
- Reset forces IDLE and clears the pending mount. Output reset values: `sd_ack=0`, `sd_buff_wr=0`, `sd_buff_addr=0`, `sd_buff_dout=0`, `err=0`, `img_mounted=0`, `img_readonly=0`, `img_size=0`.

## Timing
- Cycle 0 is the accept edge in IDLE. `sd_ack` is high from cycle 1.
- Read:
  - Cycle 1 is RD_PRIME.
  - `sd_buff_wr` is high in cycles 2..257, with `sd_buff_addr` = 0..255.
  - `sd_ack` falls at cycle 258.
- Write:
  - Word i address is valid in cycles 1+2i and 2+2i. Data is captured at the edge ending cycle 2+2i.
  - `sd_ack` falls at cycle 513.
- `sd_buff_wr` is never high while `sd_ack` is low.
- The initiator drops its request on the `sd_ack` rise. The GAP state guarantees `sd_ack` is low for at least one cycle between blocks.
- A request re-raised in GAP is accepted in the following IDLE cycle.
- `sd_buff_addr` wraps only at block end. The counter is 8 bits with a terminal flag at 255.
- Reset mid-transfer: outputs take reset values on the next edge. The partial block stays partially written.

## Structure
- Package `sd_ramdisk_pkg` holds:
  - the state enum;
  - `BLOCK_WORDS=256`;
  - `BLOCK_BYTES=512`;
  - the function computing `img_size` from LBA_BITS.
- Sub-module `ramdisk_mem`: single-port 2^(LBA_BITS+8) x 16 synchronous RAM, with 1-cycle read latency and a write enable.
- The FSM, word counter, and mount logic live in `sd_ramdisk`.

## Test plan
- Mount with `readonly=0`:
  - `mount` pulse -> `img_mounted` high exactly 1 cycle, `img_size=32768`, `img_readonly=0`.
- Write then read:
  - Write lba 5 with `din = addr ^ 16'hA5A5` -> `sd_ack` high cycles 1..512.
  - Then read lba 5 -> 256 consecutive `sd_buff_wr` strobes, addr 0..255, data `addr ^ 16'hA5A5`.
- Save-flow loop:
  - Sequencer-style writes to lba 16..31, re-raising the request on the `sd_ack` fall -> all 16 blocks complete.
  - Read-back matches; `sd_ack` is low at least 1 cycle between blocks.
- Readonly:
  - Remount with `readonly=1`, write lba 5 with 0xFFFF -> full handshake completes; read of lba 5 still returns the `^A5A5` pattern.
- Out of range:
  - Read lba 64 -> `err` pulses once, 256 strobes of 0x0000.
  - Write lba 64 -> no RAM write; lba 0 is unchanged.
- Priority and reset:
  - `sd_rd` and `sd_wr` both high -> read is performed.
  - Reset at cycle 100 of a read -> `sd_ack=0` next cycle; a subsequent read of lba 5 completes normally.
